// File: rtl/text_dump_pkg.sv
// Shared constants for the text-buffer-to-UART dumper: state codes, control bytes, default geometry.
package text_dump_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CR_CHAR    = 8'h0D;
  localparam logic [7:0] LF_CHAR    = 8'h0A;
  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_CR    = 3'd4;
  localparam logic [2:0] S_LF    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Cleared cells hold 0; they go out as a space so the terminal keeps its column alignment.
  function automatic logic [7:0] ascii_to_byte(input logic [6:0] c);
    return (c == 7'd0) ? SPACE_CHAR : {1'b0, c};
  endfunction

endpackage

// File: rtl/text_dump_uart_tx.sv
// Walks the text RAM row by row and streams each cell plus CR[/LF] into a UART TX FIFO.
// States: IDLE wait start | ADDR RAM latency | LATCH grab char | SEND write char | CR/LF line end | DONE pulse.
module text_dump_uart_tx
  import text_dump_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int APPEND_LF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] rd_addr,
  input  logic [6:0]  rd_data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [7:0]  wr_data
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  logic [2:0] state;
  logic [6:0] col;
  logic [4:0] row;
  logic [7:0] char_q;
  logic       row_end;

  // Writes are gated combinationally by tx_full so a strobe can never land on a full FIFO.
  assign wr_uart = !tx_full && (state == S_SEND || state == S_CR || state == S_LF);
  assign row_end = !tx_full && ((state == S_CR && APPEND_LF == 0) || state == S_LF);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_comb begin
    wr_data = 8'h00;
    if (wr_uart) begin
      case (state)
        S_SEND:  wr_data = char_q;
        S_CR:    wr_data = CR_CHAR;
        S_LF:    wr_data = LF_CHAR;
        default: wr_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      row     <= 5'd0;
      col     <= 7'd0;
      rd_addr <= 12'd0;
      char_q  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row     <= 5'd0;
            col     <= 7'd0;
            rd_addr <= 12'd0;
            state   <= S_ADDR;
          end
        end
        S_ADDR:  state <= S_LATCH;
        S_LATCH: begin
          char_q <= ascii_to_byte(rd_data);
          state  <= S_SEND;
        end
        S_SEND: begin
          if (!tx_full) begin
            if (col < COL_LAST) begin
              col     <= col + 7'd1;
              rd_addr <= {row, col + 7'd1};
              state   <= S_ADDR;
            end else begin
              state <= S_CR;
            end
          end
        end
        S_CR: begin
          if (!tx_full && APPEND_LF != 0) state <= S_LF;
        end
        S_LF:    state <= S_LF;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Shared line-end step, reached from CR (no LF) or from LF.
      if (row_end) begin
        if (row < ROW_LAST) begin
          row     <= row + 5'd1;
          col     <= 7'd0;
          rd_addr <= {row + 5'd1, 7'd0};
          state   <= S_ADDR;
        end else begin
          state <= S_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_dump_uart_tx.sv
// Scoreboard bench: two dumper instances (with and without LF) against a byte-stream reference model.
module tb_text_dump_uart_tx;

  logic        clk = 1'b0;
  logic        reset, tx_full;
  logic        start0, start1;
  logic        busy0, busy1, done0, done1, wr0, wr1;
  logic [11:0] addr0, addr1;
  logic [6:0]  rdd0, rdd1;
  logic [7:0]  wd0, wd1;

  logic [6:0]  mem [4096];
  logic [7:0]  exp_q0 [$];
  logic [7:0]  exp_q1 [$];
  logic [7:0]  got_log [2500];
  logic [7:0]  e;

  int checks = 0, failures = 0;
  int nbytes = 0, done_cnt0 = 0, done_cnt1 = 0, lf_seen1 = 0;
  bit aborted;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdd0 <= mem[addr0];
    rdd1 <= mem[addr1];
  end

  text_dump_uart_tx #(.COLS(80), .ROWS(30), .APPEND_LF(1)) u0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .rd_addr(addr0), .rd_data(rdd0), .tx_full(tx_full), .wr_uart(wr0), .wr_data(wd0));

  text_dump_uart_tx #(.COLS(80), .ROWS(30), .APPEND_LF(0)) u1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .rd_addr(addr1), .rd_data(rdd1), .tx_full(tx_full), .wr_uart(wr1), .wr_data(wd1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every byte the DUT hands over is compared with the head of its expectation queue.
  always @(negedge clk) begin
    if (wr0) begin
      check("tx_full_guard0", {31'd0, tx_full}, 32'd0);
      if (exp_q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wr0 actual=%0h required=none", wd0);
      end else begin
        e = exp_q0.pop_front();
        check("byte0", {24'd0, wd0}, {24'd0, e});
      end
      if (nbytes < 2500) got_log[nbytes] = wd0;
      nbytes++;
    end
    if (wr1) begin
      check("tx_full_guard1", {31'd0, tx_full}, 32'd0);
      if (exp_q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wr1 actual=%0h required=none", wd1);
      end else begin
        e = exp_q1.pop_front();
        check("byte1", {24'd0, wd1}, {24'd0, e});
      end
      if (wd1 == 8'h0A) lf_seen1++;
      if (nbytes < 2500) got_log[nbytes] = wd1;
      nbytes++;
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  // Reference: the screen read in raster order, blanks for empty cells, line terminator per row.
  task automatic gen_expect(input int inst);
    logic [7:0] b;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 80; c++) begin
        b = {1'b0, mem[r * 128 + c]};
        if (b == 8'h00) b = 8'h20;
        if (inst == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
      end
      if (inst == 0) begin
        exp_q0.push_back(8'h0D);
        exp_q0.push_back(8'h0A);
      end else begin
        exp_q1.push_back(8'h0D);
      end
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 4096; i++) begin
      if (mode == 0) mem[i] = 7'h41;
      else if (mode == 1) mem[i] = 7'h00;
      else mem[i] = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v; else start1 = v;
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  function automatic logic [11:0] get_addr(input int inst);
    return (inst == 0) ? addr0 : addr1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy0"}, {31'd0, busy0}, 0);
    check({tag, "_done0"}, {31'd0, done0}, 0);
    check({tag, "_wr0"},   {31'd0, wr0},   0);
    check({tag, "_wd0"},   {24'd0, wd0},   0);
    check({tag, "_addr0"}, {20'd0, addr0}, 0);
    check({tag, "_busy1"}, {31'd0, busy1}, 0);
    check({tag, "_wr1"},   {31'd0, wr1},   0);
    check({tag, "_addr1"}, {20'd0, addr1}, 0);
  endtask

  task automatic run_dump(input int inst, input bit bp, input int stall_at,
                          input int restart_at, input int reset_at, output bit abrt);
    int exp_len, d_before, stall_left, held_bytes;
    bit stalled, restarted;
    logic [11:0] held_addr;
    abrt = 0; stalled = 0; restarted = 0; stall_left = 0;
    held_addr = '0; held_bytes = 0;
    nbytes = 0;
    exp_q0.delete(); exp_q1.delete();
    gen_expect(inst);
    exp_len = (inst == 0) ? exp_q0.size() : exp_q1.size();
    d_before = (inst == 0) ? done_cnt0 : done_cnt1;
    @(posedge clk); #1;
    set_start(inst, 1'b1);
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    check("busy_after_start", {31'd0, get_busy(inst)}, 1);
    check("rd_addr_first", {20'd0, get_addr(inst)}, 0);
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(posedge clk); #1;
      set_start(inst, 1'b0);
      if (get_done(inst)) begin
        check("busy_in_done", {31'd0, get_busy(inst)}, 1);
        check("byte_count", nbytes, exp_len);
        check("queue_drained", (inst == 0) ? exp_q0.size() : exp_q1.size(), 0);
        if (restart_at >= 0) set_start(inst, 1'b1);
        @(posedge clk); #1;
        set_start(inst, 1'b0);
        tx_full = 1'b0;
        check("busy_after_done", {31'd0, get_busy(inst)}, 0);
        check("done_width", {31'd0, get_done(inst)}, 0);
        repeat (5) @(posedge clk);
        #1;
        check("done_count", ((inst == 0) ? done_cnt0 : done_cnt1) - d_before, 1);
        check("idle_after_dump", {31'd0, get_busy(inst)}, 0);
        return;
      end
      if (reset_at >= 0 && nbytes >= reset_at) begin
        reset = 1'b1;
        set_start(inst, 1'b1);
        tx_full = 1'b0;
        @(posedge clk); #1;
        exp_q0.delete(); exp_q1.delete();
        check_reset_outputs("abort");
        reset = 1'b0;
        set_start(inst, 1'b0);
        held_bytes = nbytes;
        repeat (20) @(posedge clk);
        #1;
        check("no_wr_after_reset", nbytes, held_bytes);
        check("idle_after_reset", {31'd0, get_busy(inst)}, 0);
        abrt = 1;
        return;
      end
      if (stall_left > 0) begin
        check("rd_addr_hold", {20'd0, get_addr(inst)}, {20'd0, held_addr});
        check("no_wr_in_stall", nbytes, held_bytes);
        stall_left--;
        tx_full = (stall_left > 0);
      end else if (stall_at >= 0 && !stalled && nbytes >= stall_at) begin
        stalled = 1;
        stall_left = 50;
        held_addr = get_addr(inst);
        held_bytes = nbytes;
        tx_full = 1'b1;
      end else begin
        tx_full = bp ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (restart_at >= 0 && !restarted && nbytes >= restart_at) begin
        restarted = 1;
        set_start(inst, 1'b1);
      end
    end
    checks++; failures++;
    $display("FAIL dump_timeout actual=%0d required=%0d", nbytes, exp_len);
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; tx_full = 1'b0;
    fill(1);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    fill(0);
    run_dump(0, 0, -1, -1, -1, aborted);

    fill(1);
    lf_seen1 = 0;
    run_dump(1, 0, -1, -1, -1, aborted);
    check("no_lf_without_append", lf_seen1, 0);
    check("bytes_no_lf", nbytes, 2430);

    fill(0);
    run_dump(0, 0, 3 * 82 + 40, -1, -1, aborted);

    fill(0);
    run_dump(0, 0, -1, 100, -1, aborted);
    check("bytes_with_restart", nbytes, 2460);

    fill(2);
    run_dump(0, 1, -1, -1, 1000, aborted);
    check("reset_aborted", {31'd0, aborted}, 1);
    run_dump(0, 0, -1, -1, -1, aborted);
    check("bytes_after_reset", nbytes, 2460);

    fill(2);
    mem[29 * 128 + 79] = 7'h5A;
    run_dump(0, 1, -1, -1, -1, aborted);
    check("last_cell", {24'd0, got_log[2457]}, 32'h5A);
    check("last_cr",   {24'd0, got_log[2458]}, 32'h0D);
    check("last_lf",   {24'd0, got_log[2459]}, 32'h0A);

    fill(2);
    run_dump(1, 1, -1, -1, -1, aborted);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
